regfile_write_port: RTL and testbench



---
 rtl/regfile_write_port.sv | 123 ++++++++++++
 tb/tb_regfile_write_port.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_port
// Brief    : 32x64 register file write side: 2-entry request FIFO with
//            one-commit-per-cycle drain, X31 hard-wired to zero.
// Revision : 1.0
// ============================================================================
module regfile_write_port (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [4:0]      wr_addr,
    input  logic [63:0]     wr_data,
    input  logic            commit_hold,
    output logic [2047:0]   reg_q,
    output logic [31:0]     pend_mask,
    output logic            commit_valid,
    output logic [4:0]      commit_addr
);

    localparam int c_NUM_REGS = 32;
    localparam int c_DATA_W   = 64;
    localparam int c_DEPTH    = 2;

    logic [1:0]          r_count;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [4:0]          r_fifo_addr [c_DEPTH];
    logic [c_DATA_W-1:0] r_fifo_data [c_DEPTH];

    logic                w_push;
    logic                w_pop;
    logic [c_DEPTH-1:0]  w_entry_vld;
    logic [4:0]          w_head_addr;
    logic [c_DATA_W-1:0] w_head_data;
    logic [c_NUM_REGS-2:0] w_commit_sel;

    // Ready depends only on the registered occupancy, never on this cycle's pop.
    assign wr_ready = (r_count < 2'd2);
    assign w_push   = wr_valid & wr_ready;
    assign w_pop    = (r_count != 2'd0) & ~commit_hold;

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Slot validity follows from occupancy and the read pointer.
    always_comb begin
        w_entry_vld = '0;
        w_entry_vld[r_rd_ptr]  = (r_count != 2'd0);
        w_entry_vld[~r_rd_ptr] = (r_count == 2'd2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

    // Decoder and pending mask stop at bit 30; X31 never gets a select line.
    generate
        for (genvar k = 0; k < c_NUM_REGS - 1; k++) begin : g_dec
            assign w_commit_sel[k] = w_pop && (w_head_addr == 5'(k));
            assign pend_mask[k] = (w_entry_vld[0] && (r_fifo_addr[0] == 5'(k)))
                                | (w_entry_vld[1] && (r_fifo_addr[1] == 5'(k)));
        end
    endgenerate

    assign pend_mask[c_NUM_REGS-1] = 1'b0;

    generate
        for (genvar k = 0; k < c_NUM_REGS - 1; k++) begin : g_reg
            logic [c_DATA_W-1:0] r_val;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_val <= '0;
                end else if (w_commit_sel[k]) begin
                    r_val <= w_head_data;
                end
            end

            assign reg_q[k*c_DATA_W +: c_DATA_W] = r_val;
        end
    endgenerate

    assign reg_q[c_NUM_REGS*c_DATA_W-1 -: c_DATA_W] = '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_valid <= 1'b0;
            commit_addr  <= 5'd0;
        end else begin
            commit_valid <= w_pop;
            if (w_pop) begin
                commit_addr <= w_head_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_port
// Brief    : Directed bench for regfile_write_port with a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_regfile_write_port;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [4:0]    wr_addr;
    logic [63:0]   wr_data;
    logic          commit_hold;
    logic [2047:0] reg_q;
    logic [31:0]   pend_mask;
    logic          commit_valid;
    logic [4:0]    commit_addr;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    bit ready_dropped = 1'b0;

    regfile_write_port dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .commit_hold  (commit_hold),
        .reg_q        (reg_q),
        .pend_mask    (pend_mask),
        .commit_valid (commit_valid),
        .commit_addr  (commit_addr)
    );

    always #5 clk = ~clk;

    // Model: an ordered list of pending writes and a plain register array.
    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_regs [32];
    bit          m_cv;
    logic [4:0]  m_ca;

    always @(posedge clk or negedge reset_n) begin : model
        bit   acc;
        bit   com;
        ent_t e;
        if (!reset_n) begin
            q.delete();
            for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
            m_cv = 1'b0;
            m_ca = 5'd0;
        end else begin
            acc  = wr_valid && (q.size() < 2);
            com  = (q.size() != 0) && !commit_hold;
            m_cv = com;
            if (com) begin
                e = q.pop_front();
                m_ca = e.a;
                if (e.a != 5'd31) m_regs[e.a] = e.d;
            end
            if (acc) q.push_back('{a: wr_addr, d: wr_data});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [31:0] pm;
        if (chk_en && reset_n) begin
            pm = 32'd0;
            foreach (q[i]) if (q[i].a != 5'd31) pm[q[i].a] = 1'b1;
            chk("ready", 64'(wr_ready), 64'(q.size() < 2));
            chk("pend", 64'(pend_mask), 64'(pm));
            chk("cvalid", 64'(commit_valid), 64'(m_cv));
            if (m_cv) chk("caddr", 64'(commit_addr), 64'(m_ca));
            for (int k = 0; k < 32; k++)
                chk($sformatf("reg%0d", k), reg_q[k*64 +: 64], m_regs[k]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds the request until an edge accepts it; returns at the following negedge.
    task automatic write(input logic [4:0] a, input logic [63:0] d);
        bit rdy;
        bit done;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        done     = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            rdy = wr_ready;
            if (!rdy) ready_dropped = 1'b1;
            @(negedge clk);
            if (rdy) done = 1'b1;
        end
        if (!done) chk("write_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [63:0] rq(input int k);
        return reg_q[k*64 +: 64];
    endfunction

    initial begin
        reset_n     = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = 5'd0;
        wr_data     = 64'd0;
        commit_hold = 1'b0;
        #1;
        chk("rst_ready", 64'(wr_ready), 64'd1);
        chk("rst_pend", 64'(pend_mask), 64'd0);
        chk("rst_cvalid", 64'(commit_valid), 64'd0);
        chk("rst_regq_nonzero", 64'(|reg_q), 64'd0);
        cyc(2);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        cyc(1);

        // Single write to X5
        write(5'd5, 64'hDEADBEEF_00000001);
        wr_valid = 1'b0;
        chk("single_pend", 64'(pend_mask), 64'h20);
        chk("single_cv_early", 64'(commit_valid), 64'd0);
        cyc(1);
        chk("single_cv", 64'(commit_valid), 64'd1);
        chk("single_ca", 64'(commit_addr), 64'd5);
        chk("single_x5", rq(5), 64'hDEADBEEF_00000001);
        chk("single_x4", rq(4), 64'd0);
        cyc(1);
        chk("single_cv_drop", 64'(commit_valid), 64'd0);

        // Full FIFO and ordering
        commit_hold = 1'b1;
        write(5'd3, 64'd1);
        write(5'd3, 64'd2);
        chk("full_ready", 64'(wr_ready), 64'd0);
        chk("full_pend", 64'(pend_mask), 64'h8);
        wr_valid = 1'b1;
        wr_addr  = 5'd7;
        wr_data  = 64'd9;
        cyc(2);
        chk("stall_ready", 64'(wr_ready), 64'd0);
        chk("stall_x3", rq(3), 64'd0);
        commit_hold = 1'b0;
        cyc(1);
        chk("drain1_x3", rq(3), 64'd1);
        chk("drain1_ca", 64'(commit_addr), 64'd3);
        write(5'd7, 64'd9);
        wr_valid = 1'b0;
        chk("drain2_x3", rq(3), 64'd2);
        cyc(1);
        chk("x7", rq(7), 64'd9);
        chk("x3_final", rq(3), 64'd2);

        // X31 discard
        write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        wr_valid = 1'b0;
        chk("x31_pend", 64'(pend_mask), 64'd0);
        cyc(1);
        chk("x31_cv", 64'(commit_valid), 64'd1);
        chk("x31_ca", 64'(commit_addr), 64'd31);
        chk("x31_reg", rq(31), 64'd0);

        // Back-to-back X0..X31
        cyc(1);
        ready_dropped = 1'b0;
        for (int a = 0; a < 32; a++) write(5'(a), 64'(a * 3));
        wr_valid = 1'b0;
        cyc(2);
        chk("b2b_ready_held", 64'(ready_dropped), 64'd0);
        chk("b2b_x0", rq(0), 64'd0);
        chk("b2b_x1", rq(1), 64'd3);
        chk("b2b_x2", rq(2), 64'd6);
        chk("b2b_x30", rq(30), 64'd90);
        chk("b2b_x31", rq(31), 64'd0);

        // Reset with two buffered entries
        commit_hold = 1'b1;
        write(5'd1, 64'h11);
        write(5'd2, 64'h22);
        wr_valid = 1'b0;
        chk("pre_rst_pend", 64'(pend_mask), 64'h6);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(wr_ready), 64'd1);
        chk("mid_rst_pend", 64'(pend_mask), 64'd0);
        chk("mid_rst_cv", 64'(commit_valid), 64'd0);
        chk("mid_rst_x1", rq(1), 64'd0);
        chk("mid_rst_x2", rq(2), 64'd0);
        cyc(2);
        reset_n = 1'b1;
        commit_hold = 1'b0;
        cyc(3);
        chk("post_rst_cv", 64'(commit_valid), 64'd0);
        chk("post_rst_x1", rq(1), 64'd0);
        chk("post_rst_x2", rq(2), 64'd0);
        chk("post_rst_ready", 64'(wr_ready), 64'd1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
